// File: rtl/usb_fs_rx_pkt_decoder_pkg.sv
// Shared definitions for the USB full-speed receive packet decoder:
// PID byte values, CRC5/CRC16 polynomial/seed/residual constants,
// the decoder state type, the PID class type and single-bit CRC step
// helpers (used for same-cycle lookahead of the final CRC bit).
package usb_fs_rx_pkt_decoder_pkg;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SOF   = 8'hA5;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [4:0]  CRC5_POLY   = 5'h05;
  localparam logic [4:0]  CRC5_INIT   = 5'h1F;
  localparam logic [4:0]  CRC5_RESID  = 5'h0C;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_BODY,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Packet class is carried in PID[1:0].
  typedef enum logic [1:0] {
    CLS_SPECIAL   = 2'b00,
    CLS_TOKEN     = 2'b01,
    CLS_HANDSHAKE = 2'b10,
    CLS_DATA      = 2'b11
  } pid_class_e;

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    crc5_step = {c[3:0], 1'b0} ^ ((c[4] ^ b) ? CRC5_POLY : 5'h00);
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_fs_rx_pkt_decoder_if.sv
// Bit-layer -> decoder -> protocol-engine signal bundle.
//   bit_*  : destuffed bit stream and framing pulses from the bit receiver
//   rx_*   : decoded packet strobes, header fields and data byte stream
// master : bit-layer / consumer side (drives bit_*, observes rx_*)
// slave  : decoder side (consumes bit_*, drives rx_*)
interface usb_fs_rx_pkt_decoder_if;
  logic        bit_pkt_start;
  logic        bit_strobe;
  logic        bit_data;
  logic        bit_pkt_end;
  logic        bit_err;

  logic        rx_pkt_start;
  logic        rx_pkt_end;
  logic        rx_pkt_valid;
  logic [3:0]  rx_pid;
  logic [6:0]  rx_addr;
  logic [3:0]  rx_endp;
  logic [10:0] rx_frame_num;
  logic        rx_data_put;
  logic [7:0]  rx_data;

  modport master (
    output bit_pkt_start, bit_strobe, bit_data, bit_pkt_end, bit_err,
    input  rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_pid, rx_addr,
           rx_endp, rx_frame_num, rx_data_put, rx_data
  );

  modport slave (
    input  bit_pkt_start, bit_strobe, bit_data, bit_pkt_end, bit_err,
    output rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_pid, rx_addr,
           rx_endp, rx_frame_num, rx_data_put, rx_data
  );
endinterface

// File: rtl/usb_fs_rx_pkt_decoder_crc.sv
// Serial CRC register, one bit per enabled cycle.
//   clk, reset_n : clock, async active-low reset (register -> INIT)
//   clear        : reload INIT (start of packet)
//   en, bit_in   : shift one received bit into the CRC
//   crc          : current register contents
module usb_fs_crc_serial #(
  parameter int unsigned          WIDTH = 5,
  parameter logic [WIDTH-1:0]     POLY  = '0,
  parameter logic [WIDTH-1:0]     INIT  = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc
);

  logic [WIDTH-1:0] crc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= INIT;
    end else if (clear) begin
      crc_q <= INIT;
    end else if (en) begin
      crc_q <= {crc_q[WIDTH-2:0], 1'b0} ^ ((crc_q[WIDTH-1] ^ bit_in) ? POLY : '0);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_fs_rx_pkt_decoder.sv
// USB full-speed receive packet decoder. Assembles destuffed bits
// LSB-first into bytes, checks the PID and CRC5/CRC16, extracts token
// fields and streams data bytes to the protocol engines.
//   clk, reset_n : 48 MHz clock, async active-low reset
//   bus (slave)  : bit_* inputs from the bit receiver, rx_* outputs
// MAX_PKT_BYTES bounds the packet length including PID and CRC16.
module usb_fs_rx_pkt_decoder
  import usb_fs_rx_pkt_decoder_pkg::*;
#(
  parameter int unsigned MAX_PKT_BYTES = 1026
) (
  input  logic                    clk,
  input  logic                    reset_n,
  usb_fs_rx_pkt_decoder_if.slave  bus
);

  localparam int unsigned   CNT_W   = $clog2(MAX_PKT_BYTES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_BYTES);

  state_e            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]  bytecnt_q, bytecnt_d;
  logic              ovf_q, ovf_d;
  logic              pid_ok_q, pid_ok_d;
  logic [7:0]        byte1_q, byte1_d;

  logic              start_q, start_d;
  logic              end_q, end_d;
  logic              valid_q, valid_d;
  logic [3:0]        pid_q, pid_d;
  logic [6:0]        addr_q, addr_d;
  logic [3:0]        endp_q, endp_d;
  logic [10:0]       frame_q, frame_d;
  logic              put_q, put_d;
  logic [7:0]        data_q, data_d;

  logic              bit_take, crc_en;
  logic [4:0]        crc5, crc5_la;
  logic [15:0]       crc16, crc16_la;
  logic [7:0]        new_byte;
  logic              cls_ok, verdict;

  // A restart or a line error in the same cycle suppresses the bit.
  assign bit_take = bus.bit_strobe && !bus.bit_err && !bus.bit_pkt_start &&
                    ((state_q == ST_PID) || (state_q == ST_BODY));
  assign crc_en   = bit_take && (state_q == ST_BODY);

  // Registered CRC plus this cycle's bit, so a bit arriving together
  // with EOP (or completing the token) is already reflected in checks.
  assign crc5_la  = crc_en ? crc5_step(crc5, bus.bit_data)   : crc5;
  assign crc16_la = crc_en ? crc16_step(crc16, bus.bit_data) : crc16;

  usb_fs_crc_serial #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.bit_pkt_start),
    .en      (crc_en),
    .bit_in  (bus.bit_data),
    .crc     (crc5)
  );

  usb_fs_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.bit_pkt_start),
    .en      (crc_en),
    .bit_in  (bus.bit_data),
    .crc     (crc16)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    bytecnt_d = bytecnt_q;
    ovf_d     = ovf_q;
    pid_ok_d  = pid_ok_q;
    byte1_d   = byte1_q;
    start_d   = 1'b0;
    end_d     = 1'b0;
    put_d     = 1'b0;
    valid_d   = valid_q;
    pid_d     = pid_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    frame_d   = frame_q;
    data_d    = data_q;
    new_byte  = {bus.bit_data, shift_q[7:1]};
    cls_ok    = 1'b0;
    verdict   = 1'b0;

    if (state_q == ST_DONE) state_d = ST_IDLE;

    // Bit first; an EOP in the same cycle is judged on the updated state.
    if (bit_take) begin
      shift_d  = new_byte;
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        if (state_q == ST_PID) begin
          pid_d     = new_byte[3:0];
          pid_ok_d  = (new_byte[7:4] == ~new_byte[3:0]);
          bytecnt_d = CNT_W'(1);
          state_d   = ST_BODY;
        end else if (bytecnt_q >= MAX_CNT) begin
          ovf_d = 1'b1;
        end else begin
          bytecnt_d = bytecnt_q + CNT_W'(1);
          if (pid_ok_q && (pid_class_e'(pid_q[1:0]) == CLS_DATA)) begin
            put_d  = 1'b1;
            data_d = new_byte;
          end
          if (bytecnt_q == CNT_W'(1)) byte1_d = new_byte;
          // Token fields are only taken once the CRC5 over both bytes checks.
          if ((bytecnt_q == CNT_W'(2)) && pid_ok_q &&
              (pid_class_e'(pid_q[1:0]) == CLS_TOKEN) && (crc5_la == CRC5_RESID)) begin
            if (pid_q == PID_SOF[3:0]) begin
              frame_d = {new_byte[2:0], byte1_q};
            end else begin
              addr_d = byte1_q[6:0];
              endp_d = {new_byte[2:0], byte1_q[7]};
            end
          end
        end
      end
    end

    if (bus.bit_err && ((state_q == ST_PID) || (state_q == ST_BODY))) state_d = ST_DRAIN;

    case (pid_class_e'(pid_d[1:0]))
      CLS_TOKEN:     cls_ok = (bytecnt_d == CNT_W'(3)) && (crc5_la == CRC5_RESID);
      CLS_DATA:      cls_ok = (bytecnt_d >= CNT_W'(3)) && (crc16_la == CRC16_RESID);
      CLS_HANDSHAKE: cls_ok = (bytecnt_d == CNT_W'(1));
      default:       cls_ok = 1'b0;
    endcase
    verdict = pid_ok_d && cls_ok && (bitcnt_d == 3'd0) && !ovf_d;

    if (bus.bit_pkt_end) begin
      if (state_d == ST_BODY) begin
        end_d   = 1'b1;
        valid_d = verdict;
        state_d = ST_DONE;
      end else if ((state_d == ST_PID) || (state_d == ST_DRAIN)) begin
        end_d   = 1'b1;
        valid_d = 1'b0;
        state_d = ST_DONE;
      end
    end

    // A new SYNC abandons whatever was in flight, without an end strobe.
    if (bus.bit_pkt_start) begin
      state_d   = ST_PID;
      shift_d   = '0;
      bitcnt_d  = '0;
      bytecnt_d = '0;
      ovf_d     = 1'b0;
      pid_ok_d  = 1'b0;
      byte1_d   = '0;
      start_d   = 1'b1;
      end_d     = 1'b0;
      put_d     = 1'b0;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bitcnt_q  <= '0;
      bytecnt_q <= '0;
      ovf_q     <= 1'b0;
      pid_ok_q  <= 1'b0;
      byte1_q   <= '0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      valid_q   <= 1'b0;
      pid_q     <= '0;
      addr_q    <= '0;
      endp_q    <= '0;
      frame_q   <= '0;
      put_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      bytecnt_q <= bytecnt_d;
      ovf_q     <= ovf_d;
      pid_ok_q  <= pid_ok_d;
      byte1_q   <= byte1_d;
      start_q   <= start_d;
      end_q     <= end_d;
      valid_q   <= valid_d;
      pid_q     <= pid_d;
      addr_q    <= addr_d;
      endp_q    <= endp_d;
      frame_q   <= frame_d;
      put_q     <= put_d;
      data_q    <= data_d;
    end
  end

  assign bus.rx_pkt_start = start_q;
  assign bus.rx_pkt_end   = end_q;
  assign bus.rx_pkt_valid = valid_q;
  assign bus.rx_pid       = pid_q;
  assign bus.rx_addr      = addr_q;
  assign bus.rx_endp      = endp_q;
  assign bus.rx_frame_num = frame_q;
  assign bus.rx_data_put  = put_q;
  assign bus.rx_data      = data_q;

endmodule

// File: tb/tb_usb_fs_rx_pkt_decoder.sv
module tb_usb_fs_rx_pkt_decoder;

  typedef struct {
    bit         is_end;
    logic [7:0] data;
    logic       valid;
    logic [3:0] pid;
    bit         chk_tok;
    logic [6:0] addr;
    logic [3:0] endp;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  usb_fs_rx_pkt_decoder_if bus ();

  usb_fs_rx_pkt_decoder #(.MAX_PKT_BYTES(1026)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   starts_seen = 0;
  int   starts_exp = 0;

  logic [7:0] d0 [10] = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) continue;
      if (bus.rx_pkt_start) begin
        starts_seen++;
        tests++;
        if (bus.rx_pkt_valid !== 1'b0) begin
          fails++;
          $display("FAIL start_clears_valid: got %b want 0", bus.rx_pkt_valid);
        end
      end
      if (bus.rx_data_put) begin
        tests++;
        if (q.size() == 0 || q[0].is_end) begin
          fails++;
          $display("FAIL put_unexpected: got data %h, no put expected", bus.rx_data);
        end else begin
          e = q.pop_front();
          if (bus.rx_data !== e.data) begin
            fails++;
            $display("FAIL put_data: got %h want %h", bus.rx_data, e.data);
          end
        end
      end
      if (bus.rx_pkt_end) begin
        tests++;
        if (q.size() == 0 || !q[0].is_end) begin
          fails++;
          $display("FAIL end_unexpected: got end valid=%b pid=%h", bus.rx_pkt_valid, bus.rx_pid);
        end else begin
          e = q.pop_front();
          if (bus.rx_pkt_valid !== e.valid || bus.rx_pid !== e.pid) begin
            fails++;
            $display("FAIL end_verdict: got valid=%b pid=%h want valid=%b pid=%h",
                     bus.rx_pkt_valid, bus.rx_pid, e.valid, e.pid);
          end
          if (e.chk_tok) begin
            tests++;
            if (bus.rx_addr !== e.addr || bus.rx_endp !== e.endp) begin
              fails++;
              $display("FAIL token_fields: got addr=%h endp=%h want addr=%h endp=%h",
                       bus.rx_addr, bus.rx_endp, e.addr, e.endp);
            end
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (enter and leave just after a negedge) ----------------
  task automatic push_put(input logic [7:0] d);
    exp_t e;
    e = '{is_end: 1'b0, data: d, valid: 1'b0, pid: 4'h0, chk_tok: 1'b0, addr: 7'h0, endp: 4'h0};
    q.push_back(e);
  endtask

  task automatic push_end(input logic v, input logic [3:0] p, input bit chk,
                          input logic [6:0] a, input logic [3:0] ep);
    exp_t e;
    e = '{is_end: 1'b1, data: 8'h00, valid: v, pid: p, chk_tok: chk, addr: a, endp: ep};
    q.push_back(e);
  endtask

  task automatic start_pkt();
    starts_exp++;
    bus.bit_pkt_start = 1'b1;
    @(negedge clk);
    bus.bit_pkt_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int unsigned n, input bit end_on_last);
    for (int unsigned i = 0; i < n; i++) begin
      bus.bit_strobe = 1'b1;
      bus.bit_data   = b[i];
      if (end_on_last && (i == n - 1)) bus.bit_pkt_end = 1'b1;
      @(negedge clk);
      bus.bit_strobe  = 1'b0;
      bus.bit_pkt_end = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic tok_byte(input logic [7:0] b);
    send_bits(b, 8, 1'b0);
  endtask

  task automatic data_byte(input logic [7:0] b);
    push_put(b);
    send_bits(b, 8, 1'b0);
  endtask

  task automatic finish_pkt(input logic v, input logic [3:0] p, input bit chk,
                            input logic [6:0] a, input logic [3:0] ep);
    push_end(v, p, chk, a, ep);
    bus.bit_pkt_end = 1'b1;
    @(negedge clk);
    bus.bit_pkt_end = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (bus.rx_pkt_start !== 1'b0 || bus.rx_pkt_end !== 1'b0 || bus.rx_pkt_valid !== 1'b0 ||
        bus.rx_pid !== 4'h0 || bus.rx_addr !== 7'h0 || bus.rx_endp !== 4'h0 ||
        bus.rx_frame_num !== 11'h0 || bus.rx_data_put !== 1'b0 || bus.rx_data !== 8'h00) begin
      fails++;
      $display("FAIL %s: got start=%b end=%b valid=%b pid=%h addr=%h endp=%h frame=%h put=%b data=%h want all 0",
               name, bus.rx_pkt_start, bus.rx_pkt_end, bus.rx_pkt_valid, bus.rx_pid, bus.rx_addr,
               bus.rx_endp, bus.rx_frame_num, bus.rx_data_put, bus.rx_data);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] b;
    bus.bit_pkt_start = 1'b0;
    bus.bit_strobe    = 1'b0;
    bus.bit_data      = 1'b0;
    bus.bit_pkt_end   = 1'b0;
    bus.bit_err       = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // SETUP addr 0 endp 0
    start_pkt(); tok_byte(8'h2D); tok_byte(8'h00); tok_byte(8'h10);
    finish_pkt(1'b1, 4'hD, 1'b1, 7'h00, 4'h0);

    // OUT addr 3A endp 1 with one CRC5 bit flipped: fields must stay from SETUP
    start_pkt(); tok_byte(8'hE1); tok_byte(8'hBA); tok_byte(8'h08);
    finish_pkt(1'b0, 4'h1, 1'b1, 7'h00, 4'h0);

    // OUT addr 3A endp 1, correct CRC5
    start_pkt(); tok_byte(8'hE1); tok_byte(8'hBA); tok_byte(8'h00);
    finish_pkt(1'b1, 4'h1, 1'b1, 7'h3A, 4'h1);

    // DATA0 GET_DESCRIPTOR setup payload with CRC16
    start_pkt(); tok_byte(8'hC3);
    for (int i = 0; i < 10; i++) data_byte(d0[i]);
    finish_pkt(1'b1, 4'h3, 1'b0, 7'h0, 4'h0);

    // Same packet with bit 0 of the first data byte flipped
    start_pkt(); tok_byte(8'hC3);
    for (int i = 0; i < 10; i++) begin
      b = d0[i];
      if (i == 0) b[0] = ~b[0];
      data_byte(b);
    end
    finish_pkt(1'b0, 4'h3, 1'b0, 7'h0, 4'h0);

    // ACK
    start_pkt(); tok_byte(8'hD2);
    finish_pkt(1'b1, 4'h2, 1'b0, 7'h0, 4'h0);

    // ACK followed by a stray byte
    start_pkt(); tok_byte(8'hD2); tok_byte(8'h00);
    finish_pkt(1'b0, 4'h2, 1'b0, 7'h0, 4'h0);

    // PID check failure
    start_pkt(); tok_byte(8'h2E);
    finish_pkt(1'b0, 4'hE, 1'b0, 7'h0, 4'h0);

    // Zero-length DATA1
    start_pkt(); tok_byte(8'h4B); data_byte(8'h00); data_byte(8'h00);
    finish_pkt(1'b1, 4'hB, 1'b0, 7'h0, 4'h0);

    // Zero-length DATA1 plus 3 trailing bits
    start_pkt(); tok_byte(8'h4B); data_byte(8'h00); data_byte(8'h00);
    send_bits(8'h05, 3, 1'b0);
    finish_pkt(1'b0, 4'hB, 1'b0, 7'h0, 4'h0);

    // PID too short: EOP after 5 bits
    start_pkt(); send_bits(8'hD2, 5, 1'b0);
    finish_pkt(1'b0, 4'hB, 1'b0, 7'h0, 4'h0);

    // bit_err mid-body: later bytes ignored, verdict invalid at EOP
    start_pkt(); tok_byte(8'hC3); data_byte(8'h80); data_byte(8'h06);
    bus.bit_err = 1'b1;
    @(negedge clk);
    bus.bit_err = 1'b0;
    @(negedge clk);
    tok_byte(8'h00); tok_byte(8'h01);
    finish_pkt(1'b0, 4'h3, 1'b0, 7'h0, 4'h0);

    // ACK whose last bit arrives together with EOP
    start_pkt();
    push_end(1'b1, 4'h2, 1'b0, 7'h0, 4'h0);
    send_bits(8'hD2, 8, 1'b1);
    repeat (3) @(negedge clk);

    // Restart after 12 token bits, then a complete ACK: only one end
    start_pkt(); tok_byte(8'hE1); send_bits(8'hBA, 4, 1'b0);
    start_pkt(); tok_byte(8'hD2);
    finish_pkt(1'b1, 4'h2, 1'b0, 7'h0, 4'h0);

    // Reset in the middle of a data packet: outputs clear, no end strobe
    start_pkt(); tok_byte(8'hC3); data_byte(8'h80);
    send_bits(8'h06, 3, 1'b0);
    reset_n = 1'b0;
    #1;
    check_zero("reset_mid_packet");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_zero("after_reset_idle");

    // Recovery after reset
    start_pkt(); tok_byte(8'hD2);
    finish_pkt(1'b1, 4'h2, 1'b0, 7'h0, 4'h0);

    repeat (10) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations: got %0d left want 0", q.size());
    end
    tests++;
    if (starts_seen != starts_exp) begin
      fails++;
      $display("FAIL start_count: got %0d want %0d", starts_seen, starts_exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
